frame_scanout_reader: RTL
=========================

Name: frame_scanout_reader

Overview:
Read-side engine for the dual-port frame buffer: 16-bit RGB565 pixels, 15-bit word address, several 96x64 frames stored back-to-back.
- Accepts pixel requests (pixel index 0..6143) from the OLED driver.
- Translates each request into a frame-buffer read address on the read port.
- Returns the pixel word through a fixed-latency pipeline.
- Selects which stored frame is shown, either directly or by auto-advancing animation playback.
- Frame changes only at frame boundaries, so the display never tears.

Parameters:
ADDR_W, 15, frame buffer address width
DATA_W, 16, pixel word width (RGB565)
FRAME_PIXELS, 6144, pixels per frame (96x64)
NUM_FRAMES, 5, frames stored; NUM_FRAMES*FRAME_PIXELS <= 2**ADDR_W
HOLD_W, 8, width of playback hold counter

Ports:
clk  in  1  single system clock
rst_n  in  1  reset, asynchronous, active-low
pixel_req  in  1  request strobe from OLED driver, one pixel per high cycle
pixel_index  in  13  requested pixel, row-major
pixel_data  out  DATA_W  returned pixel word
pixel_valid  out  1  pixel_data valid this cycle
bram_addr  out  ADDR_W  read address to frame-buffer port (write-enable held 0 externally)
bram_rdata  in  DATA_W  frame-buffer read data, registered in BRAM (1-cycle latency)
frame_sel  in  3  frame to display when play_en=0
play_en  in  1  1 = auto-advance animation
hold_frames  in  HOLD_W  extra displayed frames per animation step (0 = advance every frame)
cur_frame  out  3  frame currently being scanned out
frame_start  out  1  one-cycle pulse when a new frame scan begins

Behaviour:
Reset (rst_n=0, async):
- pixel_data=0, pixel_valid=0, bram_addr=0, cur_frame=0, frame_start=0.
- Hold counter=0; pipeline valid bits cleared.
- Requests in flight when reset asserts are discarded; no pixel_valid ever appears for them.

Pipeline (fully pipelined, one request per cycle, no backpressure):
- Edge E0 samples pixel_req=1: bram_addr <= base + pixel_index, stage-1 valid set.
- E1: BRAM registers bram_rdata.
- E2: pixel_data <= bram_rdata, pixel_valid=1 for exactly one cycle.
- Latency is 2 cycles from request edge to pixel_valid. Back-to-back requests give back-to-back valids in order.
- pixel_req=0: bram_addr holds its last value; no valid is generated.
- base = cur_frame*FRAME_PIXELS, held in a register and updated only at frame start.

Out-of-range pixel_index (>= FRAME_PIXELS):
- bram_addr <= base.
- Returned pixel_data forced to 0 (black); pixel_valid still asserted at the normal latency.

Frame start:
- Occurs when pixel_req=1 and pixel_index==0.
- At that edge, cur_frame/base update first, and the index-0 read uses the new base.
- frame_start pulses in the cycle after that edge.

Frame selection at each frame start:
- play_en=0: cur_frame <= frame_sel. If frame_sel >= NUM_FRAMES, cur_frame <= 0. Hold counter <= 0.
- play_en=1, hold counter < hold_frames: hold counter +1; cur_frame unchanged.
- play_en=1, hold counter == hold_frames: hold counter <= 0; cur_frame <= cur_frame+1, wrapping NUM_FRAMES-1 -> 0.
- play_en rising: playback continues from the current cur_frame; the hold counter restarts at 0 on the next frame start.

Other rules:
- frame_sel and play_en changes mid-frame take effect only at the next frame start.
- Base arithmetic: ADDR_W bits, unsigned; never exceeds NUM_FRAMES*FRAME_PIXELS-1 given the parameter constraint.

Test Plan:
1. Reset, frame_sel=2, play_en=0; req index 0 then 1; bram model returns addr as data -> frame_start pulse; bram_addr 12288, 12289; pixel_valid at +2 cycles with pixel_data 12288, 12289; cur_frame=2.
2. Burst of 6144 consecutive requests, one per cycle -> 6144 valids, contiguous, in order, each exactly 2 cycles after its request.
3. play_en=1, hold_frames=1, start cur_frame=3, six full frames -> cur_frame sequence 3,3,4,4,0,0 (wrap at NUM_FRAMES=5).
4. frame_sel changed 1->4 at pixel 3000 -> remainder of frame reads base 6144; next index-0 request uses base 24576.
5. Request index 6144 and 8191 -> pixel_data 0 with pixel_valid; bram_addr equals base.
6. Assert rst_n=0 one cycle after two requests, release -> no pixel_valid for the dropped requests; all outputs 0; cur_frame 0.

Source files
------------

// File: rtl/frame_scanout_reader.sv
// Frame-buffer read engine: maps OLED pixel requests onto the read port of the selected frame
// and returns pixels after a fixed two-cycle latency. The frame can only change at index 0.
module frame_scanout_reader #(
   parameter int unsigned ADDR_W       = 15,
   parameter int unsigned DATA_W       = 16,
   parameter int unsigned FRAME_PIXELS = 6144,
   parameter int unsigned NUM_FRAMES   = 5,
   parameter int unsigned HOLD_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              pixel_req,
   input  logic [12:0]       pixel_index,
   output logic [DATA_W-1:0] pixel_data,
   output logic              pixel_valid,
   output logic [ADDR_W-1:0] bram_addr,
   input  logic [DATA_W-1:0] bram_rdata,
   input  logic [2:0]        frame_sel,
   input  logic              play_en,
   input  logic [HOLD_W-1:0] hold_frames,
   output logic [2:0]        cur_frame,
   output logic              frame_start
);

   function automatic logic [ADDR_W-1:0] frame_base(input logic [2:0] f);
      return ADDR_W'(32'(f) * FRAME_PIXELS);
   endfunction

   logic [2:0]        cur_frame_r, next_frame_s;
   logic [ADDR_W-1:0] base_r, next_base_s, eff_base_s, addr_s;
   logic [HOLD_W-1:0] hold_r, next_hold_s;
   logic              play_prev_r, next_play_prev_s;
   logic              start_s, in_range_s;
   logic [ADDR_W-1:0] bram_addr_r;
   logic              v1_r, oor1_r, v2_r, oor2_r;
   logic [DATA_W-1:0] pixel_data_r;
   logic              pixel_valid_r, frame_start_r;

   assign start_s    = pixel_req && (pixel_index == 13'd0);
   assign in_range_s = (32'(pixel_index) < FRAME_PIXELS);

   // Frame selection decided at a frame start; all state holds otherwise.
   always_comb begin
      next_frame_s     = cur_frame_r;
      next_hold_s      = hold_r;
      next_play_prev_s = play_prev_r;
      next_base_s      = base_r;
      if (start_s) begin
         next_play_prev_s = play_en;
         if (!play_en) begin
            if (32'(frame_sel) < NUM_FRAMES) begin
               next_frame_s = frame_sel;
            end else begin
               next_frame_s = 3'd0;
            end
            next_hold_s = '0;
         end else if (!play_prev_r) begin
            // playback just enabled: show the current frame once and restart the hold count
            next_hold_s = '0;
         end else if (hold_r < hold_frames) begin
            next_hold_s = hold_r + HOLD_W'(1);
         end else begin
            next_hold_s = '0;
            if (32'(cur_frame_r) == (NUM_FRAMES - 32'd1)) begin
               next_frame_s = 3'd0;
            end else begin
               next_frame_s = cur_frame_r + 3'd1;
            end
         end
         next_base_s = frame_base(next_frame_s);
      end else begin
         next_hold_s = hold_r;
      end
   end

   // Address generation; index 0 already uses the newly selected base.
   always_comb begin
      eff_base_s = start_s ? next_base_s : base_r;
      if (in_range_s) begin
         addr_s = eff_base_s + ADDR_W'(pixel_index);
      end else begin
         addr_s = eff_base_s;
      end
   end

   // Frame state, request pipeline and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_frame_r   <= 3'd0;
         base_r        <= '0;
         hold_r        <= '0;
         play_prev_r   <= 1'b0;
         bram_addr_r   <= '0;
         v1_r          <= 1'b0;
         oor1_r        <= 1'b0;
         v2_r          <= 1'b0;
         oor2_r        <= 1'b0;
         pixel_data_r  <= '0;
         pixel_valid_r <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         cur_frame_r   <= next_frame_s;
         base_r        <= next_base_s;
         hold_r        <= next_hold_s;
         play_prev_r   <= next_play_prev_s;
         frame_start_r <= start_s;
         if (pixel_req) begin
            bram_addr_r <= addr_s;
         end
         v1_r          <= pixel_req;
         oor1_r        <= pixel_req && !in_range_s;
         v2_r          <= v1_r;
         oor2_r        <= oor1_r;
         pixel_valid_r <= v2_r;
         if (v2_r) begin
            pixel_data_r <= oor2_r ? '0 : bram_rdata;
         end
      end
   end

   assign pixel_data  = pixel_data_r;
   assign pixel_valid = pixel_valid_r;
   assign bram_addr   = bram_addr_r;
   assign cur_frame   = cur_frame_r;
   assign frame_start = frame_start_r;

endmodule
